// File: rtl/mdu_pkg.sv
// mdu_pkg: op encoding, FSM states and op classification helpers for mdu_seq
package mdu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] MDU_NOP   = 4'd0;
    localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] MDU_MTHI  = 4'd5;
    localparam logic [OP_W-1:0] MDU_MTLO  = 4'd6;
    localparam logic [OP_W-1:0] MDU_MADD  = 4'd7;
    localparam logic [OP_W-1:0] MDU_MADDU = 4'd8;
    localparam logic [OP_W-1:0] MDU_MSUB  = 4'd9;
    localparam logic [OP_W-1:0] MDU_MSUBU = 4'd10;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Multi-cycle ops: everything from MULT..DIVU and MADD..MSUBU
    function automatic logic is_mdu_long(input logic [OP_W-1:0] op);
        return (op >= MDU_MULT && op <= MDU_DIVU) || (op >= MDU_MADD && op <= MDU_MSUBU);
    endfunction

    function automatic logic is_mdu_div(input logic [OP_W-1:0] op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit with HI/LO registers, accumulate modes and cancel
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [WIDTH-1:0]  rt_data,
    input  logic              cancel,
    output logic              busy,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int W2   = 2 * WIDTH;
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [W2-1:0]     res;
    logic              wr;

    logic [W2-1:0]     acc, prod_s, prod_u, prod, res_next;
    logic [WIDTH-1:0]  abs_a, abs_b, dvs, q_u, r_u, quo, rem;
    logic              sgn_mul, sgn_div, wr_next;

    // Result computed from the accept-cycle operands and HI/LO snapshot, held until the counter expires
    always_comb begin
        acc      = {hi, lo};
        prod_s   = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
        prod_u   = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};
        sgn_mul  = op == MDU_MULT || op == MDU_MADD || op == MDU_MSUB;
        prod     = sgn_mul ? prod_s : prod_u;
        sgn_div  = op == MDU_DIV;
        abs_a    = (sgn_div && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        abs_b    = (sgn_div && rt_data[WIDTH-1]) ? -rt_data : rt_data;
        dvs      = (rt_data == '0) ? WIDTH'(1) : abs_b;
        q_u      = abs_a / dvs;
        r_u      = abs_a % dvs;
        quo      = (sgn_div && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1])) ? -q_u : q_u;
        rem      = (sgn_div && rs_data[WIDTH-1]) ? -r_u : r_u;
        res_next = (op == MDU_MULT || op == MDU_MULTU) ? prod :
                   (op == MDU_MADD || op == MDU_MADDU) ? acc + prod :
                   (op == MDU_MSUB || op == MDU_MSUBU) ? acc - prod : {rem, quo};
        wr_next  = !(is_mdu_div(op) && rt_data == '0);
    end

    // IDLE/RUN sequencer: accepts ops, counts latency, commits or discards the held result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            res   <= '0;
            wr    <= 1'b0;
        end else if (state == IDLE) begin
            if (start && !cancel && is_mdu_long(op)) begin
                state <= RUN;
                busy  <= 1'b1;
                cnt   <= is_mdu_div(op) ? DIV_N : MULT_N;
                res   <= res_next;
                wr    <= wr_next;
            end else if (start && !cancel && op == MDU_MTHI) begin
                hi <= rs_data;
            end else if (start && !cancel && op == MDU_MTLO) begin
                lo <= rs_data;
            end
        end else begin
            if (cancel || cnt == CW'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                cnt <= cnt - CW'(1);
            end
            if (!cancel && cnt == CW'(1) && wr) begin
                hi <= res[W2-1:WIDTH];
                lo <= res[WIDTH-1:0];
            end
        end
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the ALU. The decoder drives `op`/`start`; the hazard unit stalls on `busy`.
- Generalises the single-cycle mult/div/mthi/mtlo handling:
  - configurable data width and latencies;
  - accumulate modes (madd/maddu/msub/msubu);
  - cancel for exception flush.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult-class ops; must be >=1.
- DIV_CYCLES, 10, busy cycles for div-class ops; must be >=1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request to accept `op`; sampled only when busy=0.
- op  in  4  operation code (mdu_pkg encoding).
- rs_data  in  WIDTH  operand A / mthi-mtlo source.
- rt_data  in  WIDTH  operand B.
- cancel  in  1  abort in-flight op (exception flush).
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register (registered output).
- lo  out  WIDTH  LO register (registered output).

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - hi=0, lo=0, busy=0, state=IDLE, counter=0.
  - An in-flight op is discarded.
- Op codes:
  - NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - Codes 11-15 act as NOP.
- States: IDLE, RUN. Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Accept:
  - Accept happens at edge E when start=1, busy=0, cancel=0 and op is a mult/div class op.
  - At E: operands, op and the HI/LO snapshot (for accumulate) are latched; counter loads the op latency N; state goes to RUN; busy=1.
- RUN:
  - The counter decrements each edge.
  - At edge E+N the result is written to hi/lo, busy=0 and state returns to IDLE.
  - busy is high for exactly N cycles.
  - A new start is accepted in the cycle after busy falls, never on the completing edge itself.
- MTHI/MTLO:
  - At the accept edge, hi (resp. lo) is set to rs_data.
  - No busy, no state change.
- start while busy=1 is ignored entirely; the hazard unit must stall.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = signed/unsigned 2*WIDTH product.
  - MADD(U): {hi,lo} = snapshot + product.
  - MSUB(U): {hi,lo} = snapshot - product.
  - All 2*WIDTH wide, modulo 2^(2*WIDTH).
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Signed overflow: MIN_INT / -1 gives lo=MIN_INT, hi=0.
  - Divide by zero: hi/lo unchanged; busy still runs DIV_CYCLES.
- cancel:
  - When busy=1, the next edge forces IDLE, busy=0, counter=0, and hi/lo are unchanged.
  - cancel=1 blocks acceptance in the same cycle, including MTHI/MTLO.
  - cancel with busy=0 has no effect.
- cancel on the completing edge (counter==1): the cancel wins and no result is written.
- hi/lo reads are plain register outputs. The hazard unit must stall mfhi/mflo while busy=1 or while a start is being presented.
- The internal algorithm is free (iterative or delayed-combinational) provided results and timing match exactly.

Decomposition:
- Package mdu_pkg holds:
  - op encoding localparams (MDU_NOP .. MDU_MSUBU) and OP_W=4;
  - state encoding IDLE/RUN;
  - helper function is_mdu_long(op).
- Optional sub-module mdu_div_iter: restoring divider, one quotient bit per cycle, used when DIV_CYCLES >= WIDTH. Otherwise the result is computed at accept and held until the counter expires.

Test Plan:
- Reset: reset=0 mid-RUN of a DIV → hi=lo=0 and busy=0 immediately; after release, MULT accepted normally.
- MULT latency: rs=0xFFFFFFFE (-2), rt=3, start for 1 cycle → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- Signed divide:
  - DIV rs=-7 (0xFFFFFFF9), rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU by 0 → hi/lo unchanged.
- Accumulate: MTHI 0, MTLO 0xFFFFFFFF, then MADDU rs=1, rt=1 → hi=1, lo=0; then MSUB rs=1, rt=1 → hi=0, lo=0xFFFFFFFF.
- Handshake and cancel:
  - start with MTLO while busy → lo unchanged.
  - cancel asserted in 3rd busy cycle of MULT → busy=0 next edge, hi/lo keep pre-op values.
  - cancel on the completing cycle → no write.
- Parameter sweep: WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=16 → MULT 0x8000*0x8000 signed gives hi=0x4000, lo=0x0000 with one busy cycle; back-to-back starts are accepted every 2 cycles.
